// File: rtl/multicycle_maindec.sv
// multicycle_maindec
// -----------------------------------------------------------------------------
// Main control FSM for the shared-memory multicycle MIPS datapath. A Moore
// machine that sequences fetch, decode, execute, memory and writeback over
// several cycles and drives every datapath mux select and write strobe.
// Adds a memory-wait hold, optional extended opcodes (BNE/ANDI/ORI/SLTI), a
// sticky illegal-opcode trap and a wrapping retired-instruction counter.
//
// Parameters
//   EXT_OPS  1 enables BNE/ANDI/ORI/SLTI; 0 makes them illegal
//   ALUOP_W  aluop width (2 is only meaningful with EXT_OPS=0)
//   CNT_W    retired-instruction counter width
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   op[5:0]      in   opcode from the instruction register
//   hold         in   memory not ready: freeze the FSM, suppress strobes
//   iord, irwrite, pcwrite, branch, bne, memwrite, regwrite, regdst,
//   memtoreg, alusrca, zeroext                    out  datapath controls
//   alusrcb[1:0] out  00 rd2, 01 const 4, 10 imm, 11 imm<<2
//   pcsrc[1:0]   out  00 ALU, 01 ALUOut, 10 jump target
//   aluop        out  0 add, 1 sub, 2 funct, 3 slt, 4 and, 5 or
//   illegal      out  sticky trap flag
//   done         out  instruction retires this cycle
//   instr_count  out  retired instructions, wrapping
//   state[3:0]   out  current state, for debug
// -----------------------------------------------------------------------------
module multicycle_maindec #(
  parameter bit EXT_OPS = 1'b1,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               hold,
  output logic               iord,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               bne,
  output logic               memwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic               zeroext,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic               done,
  output logic [CNT_W-1:0]   instr_count,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_SLT   = 3'd3,
    ALU_AND   = 3'd4,
    ALU_OR    = 3'd5
  } alu_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;
  alu_t   alu_code;

  // Ungated strobes from the state decode; hold and reset mask them below.
  logic ir_raw, pc_raw, mw_raw, rw_raw, br_raw, retire;
  logic stall;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    // TRAP has no exits, so hold changes nothing there either.
    if (!hold) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW:             state_d = S_MEMADR;
            OP_RTYPE:                 state_d = S_EXECUTE;
            OP_BEQ:                   state_d = S_BRANCH;
            OP_ADDI:                  state_d = S_IEXEC;
            OP_J:                     state_d = S_JUMP;
            OP_BNE:                   state_d = EXT_OPS ? S_BRANCH : S_TRAP;
            OP_ANDI, OP_ORI, OP_SLTI: state_d = EXT_OPS ? S_IEXEC : S_TRAP;
            default:                  state_d = S_TRAP;
          endcase
        end
        // Only LW and SW reach MEMADR, so anything but SW is a load.
        S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state_d = S_MEMWB;
        S_EXECUTE: state_d = S_ALUWB;
        S_IEXEC:   state_d = S_IWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_IWB, S_BRANCH, S_JUMP:
                   state_d = S_FETCH;
        S_TRAP:    state_d = S_TRAP;
        default:   state_d = S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case, so no state leaves
    // one unassigned and no latch is inferred.
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    zeroext  = 1'b0;
    bne      = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alu_code = ALU_ADD;
    ir_raw   = 1'b0;
    pc_raw   = 1'b0;
    mw_raw   = 1'b0;
    rw_raw   = 1'b0;
    br_raw   = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        ir_raw  = 1'b1;
        pc_raw  = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw_raw   = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mw_raw = 1'b1;
        retire = 1'b1;
      end
      S_EXECUTE: begin
        alusrca  = 1'b1;
        alu_code = ALU_FUNCT;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        rw_raw = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        alu_code = ALU_SUB;
        pcsrc    = 2'b01;
        br_raw   = 1'b1;
        bne      = EXT_OPS && (op == OP_BNE);
        retire   = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (EXT_OPS) begin
          case (op)
            OP_ANDI: begin
              alu_code = ALU_AND;
              zeroext  = 1'b1;
            end
            OP_ORI: begin
              alu_code = ALU_OR;
              zeroext  = 1'b1;
            end
            OP_SLTI: alu_code = ALU_SLT;
            default: alu_code = ALU_ADD;
          endcase
        end
      end
      S_IWB: begin
        rw_raw = 1'b1;
        retire = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pc_raw = 1'b1;
        retire = 1'b1;
      end
      default: ;  // TRAP drives nothing; illegal is a register
    endcase
  end

  // Strobes are suppressed while memory stalls and while reset is held, so an
  // instruction aborted by reset never writes anything. Mux selects are not
  // gated: they keep showing the current state's values.
  assign stall    = hold | reset;
  assign irwrite  = ir_raw & ~stall;
  assign pcwrite  = pc_raw & ~stall;
  assign memwrite = mw_raw & ~stall;
  assign regwrite = rw_raw & ~stall;
  assign branch   = br_raw & ~stall;
  assign done     = retire & ~stall;

  // Narrow aluop drops the upper bit; only codes 0-3 occur without EXT_OPS.
  assign aluop = ALUOP_W'(alu_code);
  assign state = state_q;

  // ---------------------------------------------------------------------------
  // State, trap flag and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal <= 1'b1;
      end
      if (done) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec. A driver issues instructions and
// pushes the expected per-instruction behaviour into a scoreboard; a monitor
// accumulates what the DUT does over each instruction and compares when done
// fires. Directed sections cover reset, trap, reset abort and counter wrap.
module tb_multicycle_maindec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: EXT_OPS=1, ALUOP_W=3, CNT_W=16 ----------------
  logic        reset_a, hold_a;
  logic [5:0]  op_a;
  logic        iord_a, irwrite_a, pcwrite_a, branch_a, bne_a, memwrite_a;
  logic        regwrite_a, regdst_a, memtoreg_a, alusrca_a, zeroext_a;
  logic [1:0]  alusrcb_a, pcsrc_a;
  logic [2:0]  aluop_a;
  logic        illegal_a, done_a;
  logic [15:0] instr_count_a;
  logic [3:0]  state_a;

  multicycle_maindec #(.EXT_OPS(1'b1), .ALUOP_W(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .hold(hold_a),
    .iord(iord_a), .irwrite(irwrite_a), .pcwrite(pcwrite_a), .branch(branch_a),
    .bne(bne_a), .memwrite(memwrite_a), .regwrite(regwrite_a), .regdst(regdst_a),
    .memtoreg(memtoreg_a), .alusrca(alusrca_a), .zeroext(zeroext_a),
    .alusrcb(alusrcb_a), .pcsrc(pcsrc_a), .aluop(aluop_a), .illegal(illegal_a),
    .done(done_a), .instr_count(instr_count_a), .state(state_a)
  );

  // ---------------- DUT B: EXT_OPS=0, ALUOP_W=2, CNT_W=4 ----------------
  logic        reset_b, hold_b;
  logic [5:0]  op_b;
  logic        iord_b, irwrite_b, pcwrite_b, branch_b, bne_b, memwrite_b;
  logic        regwrite_b, regdst_b, memtoreg_b, alusrca_b, zeroext_b;
  logic [1:0]  alusrcb_b, pcsrc_b;
  logic [1:0]  aluop_b;
  logic        illegal_b, done_b;
  logic [3:0]  instr_count_b;
  logic [3:0]  state_b;

  multicycle_maindec #(.EXT_OPS(1'b0), .ALUOP_W(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .hold(hold_b),
    .iord(iord_b), .irwrite(irwrite_b), .pcwrite(pcwrite_b), .branch(branch_b),
    .bne(bne_b), .memwrite(memwrite_b), .regwrite(regwrite_b), .regdst(regdst_b),
    .memtoreg(memtoreg_b), .alusrca(alusrca_b), .zeroext(zeroext_b),
    .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .aluop(aluop_b), .illegal(illegal_b),
    .done(done_b), .instr_count(instr_count_b), .state(state_b)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of one instruction with hold cycles removed.
  // path: state of active cycle i in nibble i. x3: outputs in the third
  // active cycle (the execute-like state after DECODE).
  typedef struct {
    logic [5:0]  op;
    int          cycles;
    logic [19:0] path;
    int          n_pc, n_mw, n_rw, n_br;
    logic [2:0]  alu3;
    logic        zx3, bne3;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [5:0] o);
    exp_t e;
    e.op = o; e.cycles = 0; e.path = '0;
    e.n_pc = 1; e.n_mw = 0; e.n_rw = 0; e.n_br = 0;
    e.alu3 = 3'd0; e.zx3 = 1'b0; e.bne3 = 1'b0;
    case (o)
      6'b100011: begin e.cycles = 5; e.path = 20'h43210; e.n_rw = 1; end              // LW
      6'b101011: begin e.cycles = 4; e.path = 20'h05210; e.n_mw = 1; end              // SW
      6'b000000: begin e.cycles = 4; e.path = 20'h07610; e.n_rw = 1; e.alu3 = 3'd2; end // R
      6'b000100: begin e.cycles = 3; e.path = 20'h00810; e.n_br = 1; e.alu3 = 3'd1; end // BEQ
      6'b000101: begin e.cycles = 3; e.path = 20'h00810; e.n_br = 1; e.alu3 = 3'd1; e.bne3 = 1'b1; end
      6'b001000: begin e.cycles = 4; e.path = 20'h0A910; e.n_rw = 1; end              // ADDI
      6'b001100: begin e.cycles = 4; e.path = 20'h0A910; e.n_rw = 1; e.alu3 = 3'd4; e.zx3 = 1'b1; end
      6'b001101: begin e.cycles = 4; e.path = 20'h0A910; e.n_rw = 1; e.alu3 = 3'd5; e.zx3 = 1'b1; end
      6'b001010: begin e.cycles = 4; e.path = 20'h0A910; e.n_rw = 1; e.alu3 = 3'd3; end // SLTI
      6'b000010: begin e.cycles = 3; e.path = 20'h00B10; e.n_pc = 2; end              // J
      default:   e.cycles = 0;
    endcase
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic        mon_en = 1'b0;
  int          act, n_ir, n_pc, n_mw, n_rw, n_br;
  logic [19:0] trace;
  logic [2:0]  alu3;
  logic        zx3, bne3;
  logic [15:0] exp_cnt;

  always @(negedge clk) begin
    if (reset_a === 1'b1 || !mon_en) begin
      act = 0; n_ir = 0; n_pc = 0; n_mw = 0; n_rw = 0; n_br = 0;
      trace = '0; alu3 = '0; zx3 = 1'b0; bne3 = 1'b0;
      if (reset_a === 1'b1) exp_cnt = '0;
    end else if (hold_a) begin
      check("hold_strobes", {26'd0, irwrite_a, pcwrite_a, memwrite_a, regwrite_a, branch_a, done_a}, 32'd0);
    end else begin
      if (act < 5) trace[4*act +: 4] = state_a;
      if (act == 2) begin
        alu3 = aluop_a; zx3 = zeroext_a; bne3 = bne_a;
      end
      n_ir += int'(irwrite_a); n_pc += int'(pcwrite_a); n_mw += int'(memwrite_a);
      n_rw += int'(regwrite_a); n_br += int'(branch_a);
      act++;
      if (done_a) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cycles",   act,   e.cycles);
          check("path",     trace, e.path);
          check("irwrites", n_ir,  1);
          check("pcwrites", n_pc,  e.n_pc);
          check("memwrite", n_mw,  e.n_mw);
          check("regwrite", n_rw,  e.n_rw);
          check("branch",   n_br,  e.n_br);
          check("aluop_x",  alu3,  e.alu3);
          check("zeroext",  zx3,   e.zx3);
          check("bne",      bne3,  e.bne3);
          check("count",    instr_count_a, exp_cnt);
          exp_cnt = exp_cnt + 16'd1;
        end
        act = 0; n_ir = 0; n_pc = 0; n_mw = 0; n_rw = 0; n_br = 0;
        trace = '0; alu3 = '0; zx3 = 1'b0; bne3 = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one instruction on DUT A starting in its FETCH cycle. Hold is
  // forced on cycles flagged in mask, plus randomly at hold_pct percent.
  task automatic run_instr(input logic [5:0] o, input int hold_pct,
                           input logic [15:0] mask, output int n);
    bit fin;
    fin = 1'b0;
    n = 0;
    sb.push_back(model(o));
    op_a = o;
    while (!fin && n < 100) begin
      hold_a = (n < 16 && mask[n]) || ($urandom_range(99) < hold_pct);
      @(negedge clk);
      fin = done_a;
      @(posedge clk);
      #1;
      n++;
    end
    hold_a = 1'b0;
    check("instr_done", fin, 1'b1);
  endtask

  logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};

  initial begin
    int n, dones;
    logic [15:0] cnt0;
    logic any_strobe, ill_ok, rw_seen, found;

    reset_a = 1'b1; hold_a = 1'b0; op_a = 6'b100011;
    reset_b = 1'b1; hold_b = 1'b0; op_b = 6'b000010;
    repeat (2) @(negedge clk);

    // Reset state: FETCH mux values, strobes forced low.
    check("rst_state",   state_a, 4'd0);
    check("rst_illegal", illegal_a, 1'b0);
    check("rst_count",   instr_count_a, 16'd0);
    check("rst_strobes", {irwrite_a, pcwrite_a, memwrite_a, regwrite_a, branch_a, done_a}, 6'd0);
    check("rst_alusrcb", alusrcb_a, 2'b01);

    @(posedge clk); #1;
    reset_a = 1'b0;
    mon_en  = 1'b1;

    // LW straight after reset.
    run_instr(6'b100011, 0, 16'h0, n);
    check("lw_len", n, 5);
    // SW, R-type, BEQ back to back.
    run_instr(6'b101011, 0, 16'h0, n);
    run_instr(6'b000000, 0, 16'h0, n);
    run_instr(6'b000100, 0, 16'h0, n);
    check("beq_len", n, 3);
    // Extended opcodes.
    run_instr(6'b001101, 0, 16'h0, n);
    run_instr(6'b000101, 0, 16'h0, n);
    // LW with 3 hold cycles in FETCH and 3 in MEMRD.
    run_instr(6'b100011, 0, 16'h01C7, n);
    check("lw_hold_len", n, 11);

    // Random legal instructions with random memory stalls.
    for (int i = 0; i < 150; i++) begin
      run_instr(legal_ops[$urandom_range(9)], 25, 16'h0, n);
    end

    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);

    // Illegal opcode: TRAP is absorbing and silent, hold is irrelevant.
    op_a = 6'b111111;
    @(negedge clk);  // FETCH
    @(negedge clk);  // DECODE
    cnt0 = instr_count_a;
    any_strobe = 1'b0;
    ill_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      hold_a = 1'($urandom_range(1));
      @(negedge clk);
      any_strobe |= irwrite_a | pcwrite_a | memwrite_a | regwrite_a | branch_a | done_a;
      if (illegal_a !== 1'b1 || state_a !== 4'd12) ill_ok = 1'b0;
    end
    check("trap_state",   state_a, 4'd12);
    check("trap_sticky",  ill_ok, 1'b1);
    check("trap_strobes", any_strobe, 1'b0);
    check("trap_count",   instr_count_a, cnt0);
    @(posedge clk); #1;
    hold_a = 1'b0;
    reset_a = 1'b1;
    @(negedge clk);
    check("trap_rst_illegal", illegal_a, 1'b0);
    check("trap_rst_state",   state_a, 4'd0);
    @(posedge clk); #1;
    reset_a = 1'b0;

    // One R-type retires, then reset aborts the next one as it enters ALUWB.
    op_a = 6'b000000;
    repeat (4) @(negedge clk);
    check("pre_abort_count", instr_count_a, 16'd0);
    @(posedge clk); #1;
    rw_seen = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      rw_seen |= regwrite_a;
      if (state_a == 4'd6) found = 1'b1;
    end
    check("abort_reached_exec", found, 1'b1);
    check("abort_prev_count", instr_count_a, 16'd1);
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(negedge clk);
    rw_seen |= regwrite_a;
    check("abort_state",    state_a, 4'd0);
    check("abort_count",    instr_count_a, 16'd0);
    check("abort_regwrite", rw_seen, 1'b0);
    @(posedge clk); #1;
    reset_a = 1'b0;

    // DUT B: 17 jumps wrap a 4-bit counter to 1.
    reset_b = 1'b0;
    dones = 0;
    for (int c = 0; c < 200 && dones < 17; c++) begin
      @(negedge clk);
      if (done_b) dones++;
    end
    @(posedge clk); #1;
    check("wrap_dones", dones, 17);
    check("wrap_count", instr_count_b, 4'd1);

    // DUT B: ORI is illegal without EXT_OPS.
    reset_b = 1'b1;
    op_b = 6'b001101;
    @(negedge clk);
    @(posedge clk); #1;
    reset_b = 1'b0;
    @(negedge clk);  // FETCH
    @(negedge clk);  // DECODE
    check("b_decode_illegal", illegal_b, 1'b0);
    @(negedge clk);
    check("b_ori_trap",    state_b, 4'd12);
    check("b_ori_illegal", illegal_b, 1'b1);
    check("b_trap_aluop",  aluop_b, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_maindec.md
# multicycle_maindec

Parametrised multicycle main control FSM for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds a memory-wait hold, optional extended I-type/branch opcodes, an illegal-opcode trap and a retired-instruction counter. It sits beside the shared-memory multicycle datapath and drives all of its mux selects and write strobes.

## Interface
- EXT_OPS, 1, enables BNE/ANDI/ORI/SLTI; 0 means those opcodes are illegal
- ALUOP_W, 3, aluop width; 2 is legal only with EXT_OPS=0
- CNT_W, 16, retired-instruction counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  opcode from the instruction register, stable from DECODE onward
- hold  in  1  memory not ready; freeze the FSM
- iord, irwrite, pcwrite, branch, bne, memwrite, regwrite, regdst, memtoreg, alusrca, zeroext  out  1 each  datapath controls
- alusrcb  out  2  00 rd2, 01 const 4, 10 imm, 11 imm<<2
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target
- aluop  out  ALUOP_W  0 add, 1 sub, 2 funct, 3 slt, 4 and, 5 or; upper bits are zero when ALUOP_W=2
- illegal  out  1  sticky trap flag
- done  out  1  instruction retires this cycle
- instr_count  out  CNT_W  retired instructions, wrapping
- state  out  4  current state, for debug

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXECUTE 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, TRAP 12
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> IEXEC; 000010 -> JUMP.
  - With EXT_OPS=1, DECODE also sends 000101 to BRANCH and 001100/001101/001010 to IEXEC.
  - Any other op at DECODE -> TRAP.
  - MEMADR -> MEMRD for LW, MEMWR for SW. MEMRD -> MEMWB. EXECUTE -> ALUWB. IEXEC -> IWB.
  - MEMWB, MEMWR, ALUWB, IWB, BRANCH and JUMP all return to FETCH.
  - TRAP is absorbing until reset.
- Per-state outputs (every unlisted output is 0):
  - FETCH: alusrcb=01, aluop=add, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, aluop=add.
  - MEMADR: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, aluop=funct.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=sub, pcsrc=01, branch=1; bne=1 when op=000101.
  - IEXEC: alusrca=1, alusrcb=10. aluop is add for ADDI, slt for SLTI, and for ANDI, or for ORI. zeroext=1 for ANDI and ORI.
  - IWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
  - TRAP: illegal=1.
- illegal is registered: it sets on entry to TRAP and stays set until reset.
- done=1 in MEMWB, MEMWR, ALUWB, IWB, BRANCH or JUMP when hold=0.
- instr_count increments by 1 at the clock edge ending a done cycle and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset is asynchronous. On assertion: state=FETCH, illegal=0, instr_count=0.
- While reset=1, irwrite, pcwrite, memwrite, regwrite, branch and done are forced to 0. Mux selects show FETCH values.
- The first fetch strobe occurs in the first cycle after reset deasserts.
- Cycle counts with hold=0: LW 5; SW, R-type, ADDI, ANDI, ORI and SLTI 4; BEQ, BNE and J 3.
- hold=1 in any state:
  - The state does not advance.
  - irwrite, pcwrite, memwrite, regwrite, branch and done are forced to 0, and the counter does not increment.
  - Mux selects and aluop stay at their state values.
  - The state completes in the first cycle with hold=0.
- hold has no effect in TRAP.
- Reset asserted mid-instruction aborts it immediately: no strobe fires and the counter does not increment for the aborted instruction.
- In DECODE, op is sampled combinationally for the next state. From IEXEC and BRANCH, op is used combinationally for aluop, zeroext and bne.

## Test plan
- Reset, then LW (op=100011), hold=0 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5; done=1 in cycle 5; instr_count=1.
- SW then R-type then BEQ, back to back -> 4+4+3 cycles; memwrite=1 once; pcwrite=1 in the three FETCH cycles; branch=1 once; instr_count=3.
- EXT_OPS=1: ORI (001101) -> IEXEC shows aluop=5, zeroext=1. BNE (000101) -> BRANCH shows bne=1, branch=1.
- EXT_OPS=0 with op=001101, or any EXT_OPS with op=111111 -> TRAP after DECODE; illegal stays 1 and all strobes stay 0 for 20 cycles; reset clears illegal.
- hold=1 for 3 cycles in FETCH, then again in MEMRD -> no irwrite/pcwrite during the hold; LW completes in 5+6=11 cycles; instr_count increments once.
- CNT_W=4, 17 J instructions -> instr_count wraps to 1. Reset asserted during ALUWB -> state=0, instr_count=0, regwrite never asserted.
